// File: rtl/lut_coeff_loader_pkg.sv
// Shared constants and state encoding for the interpolation coefficient loader
// and the coefficient memories it feeds.
package lut_coeff_loader_pkg;

  localparam int LUT_SEGMENT_NUM = 14;
  localparam int LUT_BIN_NUM     = 256;
  localparam int LUT_DEPTH       = LUT_SEGMENT_NUM * LUT_BIN_NUM;
  localparam int LUT_RD_LAT      = 2;
  localparam int LUT_DATA_WIDTH  = 32;
  localparam int LUT_ADDR_WIDTH  = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_FINISH = 2'd2,
    ST_CHECK  = 2'd3
  } load_state_e;

endpackage

// File: rtl/lut_seg_bin_counter.sv
// Segment/bin write-address counter: bins wrap and carry into the segment,
// with a terminal flag on the last table address.
module lut_seg_bin_counter
  import lut_coeff_loader_pkg::*;
#(
  parameter int SEGMENT_NUM = LUT_SEGMENT_NUM,
  parameter int BIN_NUM     = LUT_BIN_NUM,
  parameter int DEPTH       = LUT_DEPTH,
  parameter int ADDR_WIDTH  = LUT_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clr,
  input  logic                  i_inc,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_terminal
);

  localparam int BIN_W = $clog2(BIN_NUM);
  localparam int SEG_W = ADDR_WIDTH - BIN_W;

  logic [BIN_W-1:0] r_bin_cnt;
  logic [SEG_W-1:0] r_seg_cnt;

  // Bin counter with carry into the segment counter.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_bin_cnt <= '0;
      r_seg_cnt <= '0;
    end else if (i_inc) begin
      if (r_bin_cnt == BIN_W'(BIN_NUM - 1)) begin
        r_bin_cnt <= '0;
        if (r_seg_cnt == SEG_W'(SEGMENT_NUM - 1)) begin
          r_seg_cnt <= '0;
        end else begin
          r_seg_cnt <= r_seg_cnt + SEG_W'(1);
        end
      end else begin
        r_bin_cnt <= r_bin_cnt + BIN_W'(1);
      end
    end else begin
      r_bin_cnt <= r_bin_cnt;
      r_seg_cnt <= r_seg_cnt;
    end
  end

  assign o_addr     = {r_seg_cnt, r_bin_cnt};
  assign o_terminal = (o_addr == ADDR_WIDTH'(DEPTH - 1));

endmodule

// File: rtl/lut_coeff_loader.sv
// Streams a coefficient table into one single-port coefficient memory and
// arbitrates that port with pipeline reads. Optional checksum: LUT_LOAD_CHECKSUM_EN.
module lut_coeff_loader
  import lut_coeff_loader_pkg::*;
#(
  parameter int DATA_WIDTH  = LUT_DATA_WIDTH,
  parameter int SEGMENT_NUM = LUT_SEGMENT_NUM,
  parameter int BIN_NUM     = LUT_BIN_NUM,
  parameter int DEPTH       = LUT_DEPTH,
  parameter int ADDR_WIDTH  = LUT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_address,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  output logic                  mem_rden,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  load_state_e           r_state;
  logic                  r_in_ready;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic                  r_wren;
  logic                  r_rden;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_data;
  logic [LUT_RD_LAT-1:0] r_rd_sh;
`ifdef LUT_LOAD_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_sum;
  logic                  w_chk_beat;
`endif

  logic                  w_start_load;
  logic                  w_beat;
  logic                  w_rd_issue;
  logic [ADDR_WIDTH-1:0] w_cnt_addr;
  logic                  w_terminal;

  assign w_start_load = (r_state == ST_IDLE) && start;
  assign w_beat       = (r_state == ST_LOAD) && in_valid && r_in_ready;
  assign w_rd_issue   = (r_state == ST_IDLE) && rd_en;
`ifdef LUT_LOAD_CHECKSUM_EN
  assign w_chk_beat   = (r_state == ST_CHECK) && in_valid && r_in_ready;
`endif

  lut_seg_bin_counter #(
    .SEGMENT_NUM (SEGMENT_NUM),
    .BIN_NUM     (BIN_NUM),
    .DEPTH       (DEPTH),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_cnt (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_clr      (w_start_load),
    .i_inc      (w_beat),
    .o_addr     (w_cnt_addr),
    .o_terminal (w_terminal)
  );

  // Read-valid delay line; a read issued in IDLE always completes even if a load starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_sh <= '0;
    end else begin
      r_rd_sh <= {r_rd_sh[LUT_RD_LAT-2:0], w_rd_issue};
    end
  end

  // Load FSM with registered memory-port and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_wren     <= 1'b0;
      r_rden     <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
`ifdef LUT_LOAD_CHECKSUM_EN
      r_sum      <= '0;
`endif
    end else begin
      r_wren <= 1'b0;
      r_rden <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_rden     <= rd_en;
          r_mem_addr <= rd_address;
          if (start) begin
            r_state    <= ST_LOAD;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b1;
            r_error    <= 1'b0;
`ifdef LUT_LOAD_CHECKSUM_EN
            r_sum      <= '0;
`endif
          end
        end
        ST_LOAD: begin
          if (w_beat) begin
            r_wren     <= 1'b1;
            r_mem_addr <= w_cnt_addr;
            r_mem_data <= in_data;
`ifdef LUT_LOAD_CHECKSUM_EN
            r_sum      <= r_sum + in_data;
`endif
            if (w_terminal && in_last) begin
`ifdef LUT_LOAD_CHECKSUM_EN
              r_state    <= ST_CHECK;
`else
              r_state    <= ST_FINISH;
              r_busy     <= 1'b0;
              r_in_ready <= 1'b0;
`endif
            end else if (w_terminal || in_last) begin
              // Early or missing in_last: abort; words already written stay written.
              r_state    <= ST_IDLE;
              r_error    <= 1'b1;
              r_busy     <= 1'b0;
              r_in_ready <= 1'b0;
            end
          end
        end
`ifdef LUT_LOAD_CHECKSUM_EN
        ST_CHECK: begin
          if (w_chk_beat) begin
            r_busy     <= 1'b0;
            r_in_ready <= 1'b0;
            if (in_data == r_sum) begin
              r_state <= ST_FINISH;
            end else begin
              r_state <= ST_IDLE;
              r_error <= 1'b1;
            end
          end
        end
`endif
        ST_FINISH: begin
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_in_ready <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;
  assign mem_wren    = r_wren;
  assign mem_rden    = r_rden;
  assign mem_address = r_mem_addr;
  assign mem_data    = r_mem_data;
  assign rd_valid    = r_rd_sh[LUT_RD_LAT-1];

endmodule

// File: tb/tb_lut_coeff_loader.sv
// Directed scoreboard bench for lut_coeff_loader with a behavioural
// single-port memory (registered output). Honours LUT_LOAD_CHECKSUM_EN.
module tb_lut_coeff_loader;

  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int DEPTH = 3584;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_address = '0;
  logic          in_ready, rd_valid, mem_wren, mem_rden, busy, done, error;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_q = '0;
  logic [DW-1:0] mem_model [0:4095];

  int n_vec = 0;
  int n_err = 0;
  int n_done = 0;
  int n_wr = 0;
  int cyc = 0;
  logic          prev_wr_last = 1'b0;
  logic [AW-1:0] exp_wa_q [$];
  logic [DW-1:0] exp_wd_q [$];
  logic [DW-1:0] exp_rd_q [$];
  int            exp_rc_q [$];

  lut_coeff_loader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .rd_en       (rd_en),
    .rd_address  (rd_address),
    .rd_valid    (rd_valid),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_rden    (mem_rden),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wren) mem_model[mem_address] <= mem_data;
    if (mem_rden) mem_q <= mem_model[mem_address];
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: samples DUT outputs 1 time unit after each rising edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    chk("port_exclusive", {31'd0, mem_wren && mem_rden}, 32'd0);
    if (mem_wren) begin
      n_wr++;
      if (exp_wa_q.size() == 0) begin
        chk("unexpected_write_addr", {20'd0, mem_address}, 32'hFFFF_FFFF);
      end else begin
        chk("wr_addr", {20'd0, mem_address}, {20'd0, exp_wa_q.pop_front()});
        chk("wr_data", mem_data, exp_wd_q.pop_front());
      end
    end
    if (rd_valid) begin
      if (exp_rd_q.size() == 0) begin
        chk("unexpected_rd_valid", 32'd1, 32'd0);
      end else begin
        chk("rd_data", mem_q, exp_rd_q.pop_front());
        chk("rd_latency_cycle", cyc, exp_rc_q.pop_front());
      end
    end
    if (done) begin
      n_done++;
`ifndef LUT_LOAD_CHECKSUM_EN
      chk("done_after_last_write", {31'd0, prev_wr_last}, 32'd1);
`endif
    end
    prev_wr_last = mem_wren && (mem_address == AW'(DEPTH - 1));
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Presents n words (data = base + index); in_last on index last_at; optional 1-cycle gaps.
  task automatic stream(input int n, input int last_at, input bit gaps,
                        input logic [DW-1:0] base, output logic [DW-1:0] sum);
    int i = 0;
    int guard = 0;
    bit ph = 1'b0;
    sum = '0;
    while (i < n && guard < 4 * DEPTH) begin
      @(negedge clk);
      guard++;
      if (ph) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        ph = 1'b0;
      end else if (in_ready) begin
        in_valid = 1'b1;
        in_data  = base + DW'(i);
        in_last  = (i == last_at);
        exp_wa_q.push_back(AW'(i));
        exp_wd_q.push_back(base + DW'(i));
        sum = sum + base + DW'(i);
        i++;
        ph = gaps;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("stream_words_accepted", i, n);
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("check_word_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic full_load(input bit gaps, input bit bad_sum, input string tag);
    int d0, w0;
    logic [DW-1:0] s;
    d0 = n_done;
    w0 = n_wr;
    pulse_start();
    chk({tag, "_busy_on_start"}, {31'd0, busy}, 32'd1);
    chk({tag, "_ready_on_start"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_error_cleared"}, {31'd0, error}, 32'd0);
    stream(DEPTH, DEPTH - 1, gaps, 32'd0, s);
`ifdef LUT_LOAD_CHECKSUM_EN
    send_word(bad_sum ? s + 32'd1 : s);
`endif
    repeat (4) @(negedge clk);
    chk({tag, "_writes"}, n_wr - w0, DEPTH);
    chk({tag, "_wr_queue_empty"}, exp_wa_q.size(), 32'd0);
    chk({tag, "_done_pulses"}, n_done - d0, (bad_sum ? 32'd0 : 32'd1));
    chk({tag, "_error"}, {31'd0, error}, (bad_sum ? 32'd1 : 32'd0));
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int d0, w0;
    logic [DW-1:0] s;
    logic [AW-1:0] rd_addrs [3];
    rd_addrs[0] = 12'd5;
    rd_addrs[1] = 12'd256;
    rd_addrs[2] = 12'd3583;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_wren", {31'd0, mem_wren}, 32'd0);
    chk("rst_rden", {31'd0, mem_rden}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_mem_address", {20'd0, mem_address}, 32'd0);
    chk("rst_mem_data", mem_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full contiguous load, data = address
    full_load(1'b0, 1'b0, "full");

    // Back-to-back IDLE reads
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rd_en = 1'b1;
      rd_address = rd_addrs[k];
      exp_rd_q.push_back({20'd0, rd_addrs[k]});
      exp_rc_q.push_back(cyc + 2);
    end
    @(negedge clk);
    rd_en = 1'b0;
    repeat (5) @(negedge clk);
    chk("reads_all_returned", exp_rd_q.size(), 32'd0);

    // Gapped load: same address order, no duplicate writes
    full_load(1'b1, 1'b0, "gapped");

    // Early in_last on the 100th word
    d0 = n_done;
    w0 = n_wr;
    pulse_start();
    stream(100, 99, 1'b0, 32'd0, s);
    repeat (3) @(negedge clk);
    chk("early_last_error", {31'd0, error}, 32'd1);
    chk("early_last_busy", {31'd0, busy}, 32'd0);
    chk("early_last_ready", {31'd0, in_ready}, 32'd0);
    chk("early_last_writes", n_wr - w0, 32'd100);
    chk("early_last_no_done", n_done - d0, 32'd0);

    // Last address reached without in_last
    d0 = n_done;
    pulse_start();
    chk("restart_clears_error", {31'd0, error}, 32'd0);
    stream(DEPTH, -1, 1'b0, 32'd0, s);
    repeat (3) @(negedge clk);
    chk("no_last_error", {31'd0, error}, 32'd1);
    chk("no_last_busy", {31'd0, busy}, 32'd0);
    chk("no_last_no_done", n_done - d0, 32'd0);

    // Reset in the middle of a load, then reload
    d0 = n_done;
    pulse_start();
    stream(2000, -1, 1'b0, 32'd0, s);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_wren", {31'd0, mem_wren}, 32'd0);
    chk("midrst_no_done", n_done - d0, 32'd0);
    rst = 1'b0;
    full_load(1'b0, 1'b0, "reload");

    // start coincident with reset is dropped
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("start_with_rst_busy", {31'd0, busy}, 32'd0);
    chk("start_with_rst_ready", {31'd0, in_ready}, 32'd0);

`ifdef LUT_LOAD_CHECKSUM_EN
    // Corrupted checksum word
    full_load(1'b0, 1'b1, "badsum");
`endif

    chk("final_wr_queue_empty", exp_wa_q.size(), 32'd0);
    chk("final_rd_queue_empty", exp_rd_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lut_coeff_loader.md
Name: lut_coeff_loader

Overview:
- Runtime writer for the interpolation coefficient memories (14 segments x 256 bins, 32-bit words).
- Accepts a streamed coefficient table over a valid/ready handshake and generates the memory's address, data and write-enable in segment/bin order.
- Arbitrates the memory port between loading and the force pipeline's reads.
- Sits between the host/DMA load path and one single-port coefficient memory instance.

Parameters:
- DATA_WIDTH, 32, coefficient word width
- SEGMENT_NUM, 14, number of segments
- BIN_NUM, 256, bins per segment (power of 2)
- DEPTH, 3584, SEGMENT_NUM*BIN_NUM words
- ADDR_WIDTH, 12, memory address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a load from address 0
- in_valid  in  1  stream word valid
- in_ready  out  1  loader can accept a word
- in_data  in  DATA_WIDTH  coefficient word
- in_last  in  1  marks the final word of the table
- rd_en  in  1  pipeline read request
- rd_address  in  ADDR_WIDTH  pipeline read address
- rd_valid  out  1  mem_q carries read data for a request issued 2 cycles earlier
- mem_address  out  ADDR_WIDTH  to memory address
- mem_data  out  DATA_WIDTH  to memory data
- mem_wren  out  1  to memory wren
- mem_rden  out  1  to memory rden
- busy  out  1  load in progress
- done  out  1  one-cycle pulse on successful load completion
- error  out  1  sticky load-error flag

Behaviour:
- Reset values:
  - in_ready, rd_valid, mem_wren, mem_rden, busy, done and error are 0.
  - mem_address and mem_data are 0.
  - FSM is in IDLE; counters are 0.
- FSM states: IDLE, LOAD, FINISH.
- IDLE:
  - Reads pass through: mem_address<=rd_address and mem_rden<=rd_en, both registered.
  - Data is valid on mem_q one cycle later (memory output register), so rd_valid = rd_en delayed 2 cycles.
  - start moves the FSM to LOAD, clears bin_cnt/seg_cnt and clears error.
- LOAD:
  - busy=1, in_ready=1; rd_en is ignored (no read issued, rd_valid stays 0).
  - A beat is accepted when in_valid&&in_ready in cycle N. In cycle N+1: mem_wren=1, mem_address={seg_cnt,bin_cnt} as captured at N, mem_data=in_data.
  - bin_cnt is an 8-bit counter. It wraps 255->0 and increments seg_cnt.
  - in_last on the beat at address DEPTH-1: go to FINISH.
  - in_last on any earlier address: error=1, go to IDLE. Words already written stay written.
  - Beat at address DEPTH-1 without in_last: error=1, go to IDLE.
  - Gaps in in_valid: stall with counters held; mem_wren=0 on those cycles.
- FINISH: one cycle; done=1, busy=0, in_ready=0, then go to IDLE.
- start while busy is ignored. start coincident with rst: rst wins.
- rst mid-load: return to IDLE immediately; the partial table is left in memory and done is not asserted.
- Read requests in flight when start arrives still complete; their rd_valid pulses still appear.
- mem_wren and mem_rden are never high in the same cycle.

Optional Feature:
- Macro LUT_LOAD_CHECKSUM_EN.
- Defined:
  - The loader keeps a DATA_WIDTH-bit running sum, modulo 2^DATA_WIDTH, of all table words.
  - After the in_last beat it stays in a CHECK state (in_ready=1) and accepts exactly one more word, which is the expected checksum and is not written to memory.
  - Match: done pulse. Mismatch: error=1 and no done pulse.
- Undefined: no CHECK state; FINISH follows the last table word directly.

Decomposition:
- Shared package holds:
  - state encoding (IDLE/LOAD/FINISH/CHECK)
  - the SEGMENT_NUM/BIN_NUM/DEPTH constants shared with the coefficient memories
  - the read-latency constant RD_LAT=2
- One natural sub-module: lut_seg_bin_counter (bin/segment counter with wrap, terminal flag and clear).

Test Plan:
- Reset then start, stream 3584 words with data=address and in_last on the final word:
  - mem_wren pulses 3584 times, addresses 0..3583 in order.
  - done pulses once, 1 cycle after the last write; error=0.
- Stream with in_valid toggling every other cycle: address sequence is identical and there are no duplicate writes.
- in_last on word 100: error=1, FSM returns to IDLE, 100 writes issued, no done pulse.
- IDLE reads at addresses 5, 256, 3583 on consecutive cycles: rd_valid is high 2 cycles later for 3 cycles, and mem_q matches the loaded values 5, 256, 3583.
- rst asserted at word 2000: next cycle busy=0, in_ready=0, mem_wren=0; a new start reloads from address 0.
- With LUT_LOAD_CHECKSUM_EN, correct sum vs. corrupted sum: done pulse vs. error=1 with no done pulse.
